// File: rtl/draw_region_capture.sv
`default_nettype none
// ============================================================================
// Module      : draw_region_capture
// Description : Captures pixel-stream plots that fall inside a fixed W x H
//               screen window into an internal W*H x CW buffer, addressed
//               as (y-Y0)*W + (x-X0). The buffer has a registered read port
//               that can be used in any state.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_region_capture #(
   parameter int X0 = 39,
   parameter int Y0 = 39,
   parameter int W  = 80,
   parameter int H  = 40,
   parameter int CW = 9
) (
   input  logic          clk_i,
   input  logic          resetn_i,
   input  logic          start_i,
   input  logic          plot_i,
   input  logic [7:0]    x_i,
   input  logic [6:0]    y_i,
   input  logic [CW-1:0] colour_i,
   input  logic          rd_en_i,
   input  logic [11:0]   rd_addr_i,
   output logic [CW-1:0] rd_data_o,
   output logic          rd_valid_o,
   output logic [11:0]   pixel_count_o,
   output logic [7:0]    dropped_count_o,
   output logic          capture_done_o
);

   localparam int          DEPTH    = W * H;
   localparam logic [7:0]  X_LO     = 8'(X0);
   localparam logic [7:0]  X_HI     = 8'(X0 + W - 1);
   localparam logic [6:0]  Y_LO     = 7'(Y0);
   localparam logic [6:0]  Y_HI     = 7'(Y0 + H - 1);
   localparam logic [11:0] W_12     = 12'(W);
   localparam logic [11:0] DEPTH_M1 = 12'(DEPTH - 1);
   localparam logic [12:0] DEPTH_13 = 13'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [11:0]   pix_q, pix_d;
   logic [7:0]    drop_q, drop_d;
   logic [CW-1:0] rd_data_q;
   logic          rd_valid_q;
   logic [CW-1:0] mem_q [DEPTH];

   logic          w_in_win;
   logic [7:0]    w_xdiff;
   logic [6:0]    w_ydiff;
   logic [11:0]   w_addr;
   logic          w_wr_en;
   logic          w_rd_in_range;

   // Window membership and buffer address, derived directly from the inputs.
   // The address is meaningless outside the window but is only used when inside.
   always_comb begin
      w_in_win = (x_i >= X_LO) && (x_i <= X_HI) && (y_i >= Y_LO) && (y_i <= Y_HI);
      w_xdiff  = x_i - X_LO;
      w_ydiff  = y_i - Y_LO;
      w_addr   = ({5'd0, w_ydiff} * W_12) + {4'd0, w_xdiff};
   end

   // Next-state and counter logic; start overrides any plot in the same cycle.
   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      drop_d  = drop_q;
      w_wr_en = 1'b0;
      if (start_i) begin
         state_d = S_CAPTURE;
         pix_d   = '0;
         drop_d  = '0;
      end else if ((state_q == S_CAPTURE) && plot_i) begin
         if (w_in_win) begin
            w_wr_en = 1'b1;
            pix_d   = pix_q + 12'd1;
            if (pix_q == DEPTH_M1) begin
               state_d = S_DONE;
            end
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

   // FSM state and capture counters.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= S_IDLE;
         pix_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         drop_q  <= drop_d;
      end
   end

   // Capture buffer write port; contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         mem_q[w_addr] <= colour_i;
      end
   end

   assign w_rd_in_range = ({1'b0, rd_addr_i} < DEPTH_13);

   // Registered read port; sees pre-write contents on a same-cycle collision.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en_i;
         if (rd_en_i) begin
            rd_data_q <= w_rd_in_range ? mem_q[rd_addr_i] : '0;
         end
      end
   end

   assign rd_data_o       = rd_data_q;
   assign rd_valid_o      = rd_valid_q;
   assign pixel_count_o   = pix_q;
   assign dropped_count_o = drop_q;
   assign capture_done_o  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_draw_region_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_region_capture
// Description : Scoreboard bench for draw_region_capture: directed scenarios
//               followed by randomized plot/start/read traffic, checked
//               against a behavioural model of the capture window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_region_capture;

   localparam int X0    = 39;
   localparam int Y0    = 39;
   localparam int W     = 80;
   localparam int H     = 40;
   localparam int CW    = 9;
   localparam int DEPTH = W * H;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic          plot = 1'b0;
   logic [7:0]    x = '0;
   logic [6:0]    y = '0;
   logic [CW-1:0] colour = '0;
   logic          rd_en = 1'b0;
   logic [11:0]   rd_addr = '0;
   logic [CW-1:0] rd_data;
   logic          rd_valid;
   logic [11:0]   pixel_count;
   logic [7:0]    dropped_count;
   logic          capture_done;

   int n_checks = 0;
   int n_err    = 0;

   draw_region_capture #(
      .X0(X0), .Y0(Y0), .W(W), .H(H), .CW(CW)
   ) dut (
      .clk_i          (clk),
      .resetn_i       (resetn),
      .start_i        (start),
      .plot_i         (plot),
      .x_i            (x),
      .y_i            (y),
      .colour_i       (colour),
      .rd_en_i        (rd_en),
      .rd_addr_i      (rd_addr),
      .rd_data_o      (rd_data),
      .rd_valid_o     (rd_valid),
      .pixel_count_o  (pixel_count),
      .dropped_count_o(dropped_count),
      .capture_done_o (capture_done)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural reference model ----------------
   typedef struct {
      int unsigned data;
      bit          known;
   } rd_exp_t;

   int unsigned m_mem   [DEPTH];
   bit          m_known [DEPTH];
   rd_exp_t     rq[$];
   bit          m_capturing = 0;
   bit          m_done      = 0;
   int          m_pix       = 0;
   int          m_drop      = 0;
   bit          m_rvalid    = 0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_capturing = 0;
         m_done      = 0;
         m_pix       = 0;
         m_drop      = 0;
         m_rvalid    = 0;
         rq.delete();
      end else begin
         rd_exp_t e;
         m_rvalid = rd_en;
         if (rd_en) begin
            if (int'(rd_addr) >= DEPTH) begin
               e.data = 0; e.known = 1;
            end else begin
               e.data = m_mem[rd_addr]; e.known = m_known[rd_addr];
            end
            rq.push_back(e);
         end
         if (start) begin
            m_capturing = 1; m_done = 0; m_pix = 0; m_drop = 0;
         end else if (plot && m_capturing) begin
            int xi, yi, a;
            xi = int'(x); yi = int'(y);
            if (xi >= X0 && xi < X0 + W && yi >= Y0 && yi < Y0 + H) begin
               a = (yi - Y0) * W + (xi - X0);
               m_mem[a]   = int'(colour);
               m_known[a] = 1;
               m_pix++;
               if (m_pix == DEPTH) begin
                  m_capturing = 0; m_done = 1;
               end
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      check("rd_valid", 32'(rd_valid), 32'(m_rvalid));
      if (rd_valid === 1'b1) begin
         if (rq.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read at %0t", $time);
         end else begin
            rd_exp_t e;
            e = rq.pop_front();
            if (e.known) check("rd_data", 32'(rd_data), e.data);
         end
      end
      check("pixel_count", 32'(pixel_count), m_pix);
      check("dropped_count", 32'(dropped_count), m_drop);
      check("capture_done", 32'(capture_done), 32'(m_done));
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic st, input logic pl, input logic [7:0] xx,
                        input logic [6:0] yy, input logic [CW-1:0] col,
                        input logic re, input logic [11:0] ra);
      start = st; plot = pl; x = xx; y = yy; colour = col; rd_en = re; rd_addr = ra;
      @(posedge clk);
      #1;
      start = 0; plot = 0; x = '0; y = '0; colour = '0; rd_en = 0; rd_addr = '0;
   endtask

   task automatic px(input int xx, input int yy, input int col);
      drive(0, 1, 8'(xx), 7'(yy), CW'(col), 0, '0);
   endtask

   task automatic do_start();
      drive(1, 0, '0, '0, '0, 0, '0);
   endtask

   task automatic rd(input int a, input int exp);
      drive(0, 0, '0, '0, '0, 1, 12'(a));
      check("rd_valid_direct", 32'(rd_valid), 32'd1);
      check("rd_data_direct", 32'(rd_data), exp);
   endtask

   task automatic pulse_reset();
      resetn = 0;
      @(posedge clk); #1;
      resetn = 1;
   endtask

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      int a, c750;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pixel_count", 32'(pixel_count), 0);
      check("reset_capture_done", 32'(capture_done), 0);
      check("reset_rd_valid", 32'(rd_valid), 0);
      resetn = 1;
      @(posedge clk); #1;

      // 1: full raster capture
      do_start();
      for (int yy = Y0; yy < Y0 + H; yy++) begin
         for (int xx = X0; xx < X0 + W; xx++) begin
            a = (yy - Y0) * W + (xx - X0);
            if (a == DEPTH - 1) check("done_before_last", 32'(capture_done), 0);
            px(xx, yy, a & 9'h1FF);
         end
      end
      check("t1_capture_done", 32'(capture_done), 1);
      check("t1_pixel_count", 32'(pixel_count), 3200);
      px(50, 50, 9'h1FF);  // ignored in DONE
      check("t1_done_ignore", 32'(pixel_count), 3200);
      rd(0, 0);
      rd(81, 81);
      rd(3199, 127);

      // 2: out-of-window plots and saturation
      do_start();
      check("t2_done_cleared", 32'(capture_done), 0);
      px(38, 50, 1); px(119, 50, 2); px(50, 38, 3); px(50, 79, 4);
      check("t2_dropped", 32'(dropped_count), 4);
      check("t2_pixels", 32'(pixel_count), 0);
      rd(11 * W + 11, (11 * W + 11) & 9'h1FF);
      for (int i = 0; i < 300; i++) px(200, 100, i);
      check("t2_saturate", 32'(dropped_count), 255);

      // 3: plot in IDLE is ignored
      pulse_reset();
      px(39, 39, 9'h1AA);
      check("t3_idle_pixels", 32'(pixel_count), 0);
      do_start();
      rd(0, 0);
      check("t3_pixels", 32'(pixel_count), 0);

      // 4: restart mid-capture, start beats plot
      for (int i = 0; i < 100; i++) px(X0 + i % W, Y0 + i / W, i + 7);
      check("t4_pixels100", 32'(pixel_count), 100);
      do_start();
      check("t4_restart", 32'(pixel_count), 0);
      drive(1, 1, 8'd41, 7'd39, 9'h123, 0, '0);
      check("t4_start_plot", 32'(pixel_count), 0);
      rd(2, 9);
      px(60, 60, 5);
      check("t4_still_capturing", 32'(pixel_count), 1);

      // 5: read-before-write and out-of-range read
      drive(0, 1, 8'd40, 7'd39, 9'h055, 1, 12'd1);
      check("t5_rbw_valid", 32'(rd_valid), 1);
      check("t5_rbw_data", 32'(rd_data), 8);
      rd(1, 9'h055);
      rd(4000, 0);

      // 6: asynchronous reset mid-capture
      do_start();
      c750 = 0;
      for (int i = 0; i < 1500; i++) begin
         int col;
         col = int'($urandom_range(0, 511));
         if (i == 750) c750 = col;
         px(X0 + i % W, Y0 + i / W, col);
      end
      check("t6_pixels", 32'(pixel_count), 1500);
      #2 resetn = 0;
      #1;
      check("t6_rst_pixels", 32'(pixel_count), 0);
      check("t6_rst_done", 32'(capture_done), 0);
      check("t6_rst_rd_valid", 32'(rd_valid), 0);
      check("t6_rst_rd_data", 32'(rd_data), 0);
      @(posedge clk); #1;
      resetn = 1;
      @(posedge clk); #1;
      rd(750, c750);
      rd(1499, m_mem[1499]);

      // randomized traffic
      do_start();
      for (int i = 0; i < 6000; i++) begin
         logic          st, pl, re;
         logic [7:0]    xx;
         logic [6:0]    yy;
         st = ($urandom_range(0, 2999) == 0);
         pl = ($urandom_range(0, 99) < 80);
         if ($urandom_range(0, 99) < 85) begin
            xx = 8'($urandom_range(X0, X0 + W - 1));
            yy = 7'($urandom_range(Y0, Y0 + H - 1));
         end else begin
            xx = 8'($urandom_range(0, 255));
            yy = 7'($urandom_range(0, 127));
         end
         re = ($urandom_range(0, 99) < 30);
         drive(st, pl, xx, yy, CW'($urandom), re, 12'($urandom_range(0, 4095)));
      end
      @(negedge clk);
      @(negedge clk);
      check("queue_empty", 32'(rq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
